// File: rtl/event_router_rr.sv
// event_router_rr: round-robin arbiter moving packets from per-channel local FIFOs into the shared FIFO.
// Define ROUTER_FIFO_DIAG_EN to add fifo_counter/enable_fifo_diagnostics and overlay the counter on the diag field.

module event_router_rr_lane (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic read_n
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) read_n <= 1'b1;
    else          read_n <= ~strobe;
endmodule

module event_router_rr #(
  parameter int WIDTH       = 64,
  parameter int NUMCHANNELS = 64,
  parameter int ACK_TIMEOUT = 15,
  parameter int FIFO_CNT_W  = 12,
  parameter int DIAG_LSB    = 38,
  parameter int TALLY_W     = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUMCHANNELS*(WIDTH-1)-1:0]   input_event,
  input  logic [NUMCHANNELS-1:0]             local_fifo_empty,
  output logic [NUMCHANNELS-1:0]             read_local_fifo_n,
  input  logic                               fifo_full,
  input  logic                               fifo_ack,
`ifdef ROUTER_FIFO_DIAG_EN
  input  logic [FIFO_CNT_W-1:0]              fifo_counter,
  input  logic                               enable_fifo_diagnostics,
`endif
  output logic [WIDTH-1:0]                   channel_event_out,
  output logic                               load_event,
  output logic [TALLY_W-1:0]                 total_packets,
  output logic [TALLY_W-1:0]                 dropped_packets,
  output logic [$clog2(NUMCHANNELS)-1:0]     grant_id
);
  localparam int IDW = $clog2(NUMCHANNELS);
  localparam int DW  = WIDTH - 1;
  localparam int TOW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WAIT_ACK, S_RELEASE} state_t;

  state_t                         state, state_nxt;
  logic [IDW-1:0]                 ptr, ptr_inc, next_grant;
  logic                           found, go, ack_tmo;
  logic [TOW-1:0]                 to_cnt;
  logic [NUMCHANNELS-1:0][DW-1:0] chan_data;
  logic [DW-1:0]                  cap_data;
  logic [NUMCHANNELS-1:0]         strobe;
  logic                           diag_en;
  logic [FIFO_CNT_W-1:0]          diag_cnt;

  assign chan_data = input_event;

`ifdef ROUTER_FIFO_DIAG_EN
  assign diag_en  = enable_fifo_diagnostics;
  assign diag_cnt = fifo_counter;
`else
  assign diag_en  = 1'b0;
  assign diag_cnt = '0;
`endif

  // First non-empty channel at or above the pointer, wrapping past the top.
  always_comb begin
    int s;
    s          = 0;
    found      = 1'b0;
    next_grant = '0;
    for (int k = 0; k < NUMCHANNELS; k++) begin
      s = int'(ptr) + k;
      if (s >= NUMCHANNELS) s = s - NUMCHANNELS;
      if (!found && !local_fifo_empty[IDW'(s)]) begin
        found      = 1'b1;
        next_grant = IDW'(s);
      end
    end
  end

  assign go      = (state == S_IDLE) && !fifo_full && found;
  assign ptr_inc = (grant_id == IDW'(NUMCHANNELS - 1)) ? '0 : grant_id + 1'b1;
  assign ack_tmo = (to_cnt == TOW'(ACK_TIMEOUT - 1));

  always_comb begin
    cap_data = chan_data[grant_id];
    if (diag_en) cap_data[DIAG_LSB +: FIFO_CNT_W] = diag_cnt;
  end

  for (genvar i = 0; i < NUMCHANNELS; i++) begin : g_lane
    assign strobe[i] = go && (next_grant == IDW'(i));
    event_router_rr_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .strobe  (strobe[i]),
      .read_n  (read_local_fifo_n[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (go) state_nxt = S_READ;
      S_READ:     state_nxt = S_CAPTURE;
      S_CAPTURE:  state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (fifo_ack)     state_nxt = S_RELEASE;
                  else if (ack_tmo) state_nxt = S_IDLE;
      S_RELEASE:  if (!fifo_ack)    state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // An ack arriving on the last allowed cycle wins over the timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr               <= '0;
      grant_id          <= '0;
      to_cnt            <= '0;
      channel_event_out <= '0;
      load_event        <= 1'b0;
      total_packets     <= '0;
      dropped_packets   <= '0;
    end else begin
      case (state)
        S_IDLE: if (go) grant_id <= next_grant;
        S_CAPTURE: begin
          channel_event_out <= {~^cap_data, cap_data};
          load_event        <= 1'b1;
          to_cnt            <= '0;
        end
        S_WAIT_ACK: begin
          to_cnt <= to_cnt + 1'b1;
          if (fifo_ack) begin
            load_event    <= 1'b0;
            total_packets <= total_packets + 1'b1;
            ptr           <= ptr_inc;
          end else if (ack_tmo) begin
            load_event <= 1'b0;
            if (~&dropped_packets) dropped_packets <= dropped_packets + 1'b1;
            ptr <= ptr_inc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/event_router_rr.md
Name: event_router_rr

Overview:
- Parametrised successor to the single-priority event router. Arbitrates NUMCHANNELS per-channel local FIFOs into the shared chip FIFO using a round-robin pointer.
- Appends an odd-parity MSB to each packet and drives a load_event/fifo_ack handshake that adds a timeout and back-pressure from the shared FIFO.
- Keeps running counts of packets routed and packets dropped.
- Sits between the channel_ctrl local FIFOs and the shared FIFO.

Parameters:
- WIDTH, 64, routed packet width; channel data is WIDTH-1 bits, MSB is parity.
- NUMCHANNELS, 64, number of arbitrated channels (min 2).
- ACK_TIMEOUT, 15, WAIT_ACK cycles before the packet is dropped (min 1).
- FIFO_CNT_W, 12, width of fifo_counter.
- DIAG_LSB, 38, LSB of the diagnostic field inside channel data.
- TALLY_W, 16, width of the packet and drop counters.

Ports:
- clk  in  1  master clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- input_event  in  NUMCHANNELS*(WIDTH-1)  flattened local FIFO outputs; channel i occupies [i*(WIDTH-1) +: WIDTH-1].
- local_fifo_empty  in  NUMCHANNELS  high when local FIFO i is empty.
- read_local_fifo_n  out  NUMCHANNELS  active-low one-cycle read strobe per channel.
- fifo_full  in  1  shared FIFO full; blocks new grants.
- fifo_ack  in  1  shared FIFO write acknowledge.
- channel_event_out  out  WIDTH  routed packet {parity, data}.
- load_event  out  1  request to write channel_event_out into the shared FIFO.
- total_packets  out  TALLY_W  acknowledged packets, wraps.
- dropped_packets  out  TALLY_W  timed-out packets, saturates.
- grant_id  out  clog2(NUMCHANNELS)  channel currently or last served.
- fifo_counter, enable_fifo_diagnostics: only when ROUTER_FIFO_DIAG_EN is defined (see Optional Feature).

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - read_local_fifo_n all ones; load_event 0; channel_event_out 0.
  - total_packets 0; dropped_packets 0; grant_id 0.
  - round-robin pointer 0; state IDLE.
- All outputs are registered.
- States: IDLE, READ, CAPTURE, WAIT_ACK, RELEASE.
- IDLE, entered when fifo_full=0 and any local_fifo_empty[i]=0:
  - grant the first non-empty channel at or above the pointer, searching upward and wrapping at NUMCHANNELS-1 to 0.
  - register grant_id; next state READ.
  - fifo_full=1 holds the block in IDLE.
- READ: read_local_fifo_n[grant_id]=0 for exactly this cycle; next state CAPTURE.
- CAPTURE:
  - data = input_event slice for grant_id; parity = ~^data (odd parity over all WIDTH bits).
  - channel_event_out <= {parity, data}; load_event <= 1; next state WAIT_ACK.
- Latency: request seen in cycle N gives read strobe in cycle N+1 and load_event high from cycle N+3.
- WAIT_ACK:
  - on fifo_ack=1: load_event <= 0; total_packets++ (wraps); pointer <= grant_id+1 modulo NUMCHANNELS; next state RELEASE.
  - if ACK_TIMEOUT cycles pass without fifo_ack: load_event <= 0; dropped_packets++ (saturates at all ones); pointer advances the same way; next state IDLE.
- RELEASE: wait for fifo_ack=0, then go to IDLE. A held-high ack is never counted twice.
- channel_event_out holds its value until the next CAPTURE.
- Fairness: a continuously non-empty channel is served at most once per full pointer rotation while any other channel is non-empty.
- Simultaneous requests: the lowest index at or above the pointer wins.
- fifo_full going high during WAIT_ACK does not abort the transaction.
- reset_n low in any state: immediate return to the reset values; no read strobe is left asserted.

Optional Feature:
- Macro: ROUTER_FIFO_DIAG_EN.
- Defined:
  - adds ports fifo_counter (in, FIFO_CNT_W) and enable_fifo_diagnostics (in, 1).
  - in CAPTURE with enable_fifo_diagnostics=1, data[DIAG_LSB+FIFO_CNT_W-1 : DIAG_LSB] is replaced by fifo_counter before parity is computed.
- Undefined: the ports are absent and data passes unmodified.

Test Plan:
- Reset, then channel 0 non-empty with data 63'h0000_0000_0000_0001, ack 2 cycles after load_event for 2 cycles:
  - read_local_fifo_n[0] low one cycle.
  - channel_event_out = 64'h0000_0000_0000_0001 (parity 0).
  - total_packets = 1.
- Channels 3, 7 and 60 all non-empty, pointer 0: grants in order 3, 7, 60. Channel 3 refilled immediately is next served after 60, not before 7.
- fifo_full=1 with 5 channels pending: no read strobe and load_event stays 0. After fifo_full drops, the first grant appears 1 cycle later.
- No fifo_ack for 15 cycles: load_event falls, dropped_packets = 1, total_packets unchanged, the next channel is served.
- fifo_ack held high for 10 cycles: total_packets increments by exactly 1 and the FSM waits in RELEASE.
- With ROUTER_FIFO_DIAG_EN, enable=1, fifo_counter = 12'hABC: bits [49:38] of channel_event_out = 12'hABC and parity is correct over the modified word.
